// File: rtl/bu_pkg.sv
// Branch unit shared definitions: BrOp field encodings and BHT counter type.
package bu_pkg;
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic       BR_JUMP = 1'b1;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t CTR_SNT = 2'b00;
  localparam bht_ctr_t CTR_WNT = 2'b01;
  localparam bht_ctr_t CTR_WT  = 2'b10;
  localparam bht_ctr_t CTR_ST  = 2'b11;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic bht_ctr_t ctr_train(input bht_ctr_t c, input logic taken);
    if (taken) return (c == CTR_ST)  ? CTR_ST  : bht_ctr_t'(c + 2'b01);
    else       return (c == CTR_SNT) ? CTR_SNT : bht_ctr_t'(c - 2'b01);
  endfunction
endpackage

// File: rtl/bu_bht_if.sv
// Fetch lookup, execute resolve and statistics signals of the branch unit.
interface bu_bht_if #(parameter int XLEN = 32, parameter int STAT_W = 16);
  logic [XLEN-1:0]   pred_pc_i;
  logic              pred_taken_o;
  logic              res_valid_i;
  logic [XLEN-1:0]   res_pc_i;
  logic [XLEN-1:0]   A;
  logic [XLEN-1:0]   B;
  logic [4:0]        BrOp;
  logic              pred_i;
  logic              NextPCSrc;
  logic              flush_o;
  logic [STAT_W-1:0] br_cnt_o;
  logic [STAT_W-1:0] mispred_cnt_o;

  modport master (output pred_pc_i, res_valid_i, res_pc_i, A, B, BrOp, pred_i,
                  input  pred_taken_o, NextPCSrc, flush_o, br_cnt_o, mispred_cnt_o);
  modport slave  (input  pred_pc_i, res_valid_i, res_pc_i, A, B, BrOp, pred_i,
                  output pred_taken_o, NextPCSrc, flush_o, br_cnt_o, mispred_cnt_o);
endinterface

// File: rtl/bu_cmp.sv
// Combinational branch resolve: decodes BrOp and compares A/B.
module bu_cmp
  import bu_pkg::*;
#(parameter int XLEN = 32)
(
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      BrOp,
  output logic            taken,
  output logic            is_cond,
  output logic            is_jump
);
  always_comb begin
    taken   = 1'b0;
    is_jump = (BrOp[4] == BR_JUMP);
    // funct3 010/011 are reserved and behave as no-branch
    is_cond = (BrOp[4:3] == BR_COND) && (BrOp[2:1] != 2'b01);
    if (is_jump) taken = 1'b1;
    else if (is_cond) begin
      case (BrOp[2:0])
        F3_BEQ:  taken = (A == B);
        F3_BNE:  taken = (A != B);
        F3_BLT:  taken = ($signed(A) <  $signed(B));
        F3_BGE:  taken = ($signed(A) >= $signed(B));
        F3_BLTU: taken = (A <  B);
        F3_BGEU: taken = (A >= B);
        default: taken = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/bu_bht.sv
// Branch unit with a 2-bit saturating-counter BHT, mispredict flush and stats.
module bu_bht
  import bu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int STAT_W      = 16
)(
  input logic clk,
  input logic rst,
  bu_bht_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_ctr_t          bht [BHT_ENTRIES];
  logic [STAT_W-1:0] br_cnt, mis_cnt;
  logic              taken, is_cond, is_jump, upd, flush;
  logic [IDX_W-1:0]  pred_idx, res_idx;

  bu_cmp #(.XLEN(XLEN)) u_cmp (
    .A(bus.A), .B(bus.B), .BrOp(bus.BrOp),
    .taken(taken), .is_cond(is_cond), .is_jump(is_jump)
  );

  assign pred_idx = bus.pred_pc_i[IDX_W+1:2];
  assign res_idx  = bus.res_pc_i[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc_i[XLEN-1:IDX_W+2], bus.pred_pc_i[1:0],
                            bus.res_pc_i[XLEN-1:IDX_W+2],  bus.res_pc_i[1:0]};

  assign upd   = bus.res_valid_i && is_cond;
  // Jumps are never predicted at fetch, so every resolved jump redirects.
  assign flush = !rst && bus.res_valid_i &&
                 ((is_cond && (taken != bus.pred_i)) || is_jump);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_WNT;
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (upd) bht[res_idx] <= ctr_train(bht[res_idx], taken);
      if (upd && (br_cnt != '1))   br_cnt  <= br_cnt  + STAT_W'(1);
      if (flush && (mis_cnt != '1)) mis_cnt <= mis_cnt + STAT_W'(1);
    end
  end

  assign bus.pred_taken_o  = bht[pred_idx][1];
  assign bus.NextPCSrc     = taken;
  assign bus.flush_o       = flush;
  assign bus.br_cnt_o      = br_cnt;
  assign bus.mispred_cnt_o = mis_cnt;
endmodule

// File: doc/bu_bht.md
Name: bu_bht

Overview:
- Branch unit for the pipelined core. It resolves branches and jumps, and adds a dynamic predictor.
- Combinational resolve path: given operands A/B and BrOp from execute, it produces NextPCSrc. It keeps the single-cycle BrOp encoding and generalises the datapath to XLEN.
- Sequential part: a parametrised branch history table (BHT) of 2-bit saturating counters.
  - Fetch reads the BHT for a prediction.
  - Resolved conditional branches train the BHT.
  - A mispredict/flush signal is raised, and branch/mispredict statistics are counted.

Parameters:
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, number of 2-bit counters (power of two, >=2)
- STAT_W, 16, width of each statistics counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- pred_pc_i  in  XLEN  fetch PC for lookup
- pred_taken_o  out  1  prediction for pred_pc_i: MSB of indexed counter
- res_valid_i  in  1  execute-stage instruction valid
- res_pc_i  in  XLEN  PC of resolving instruction
- A  in  XLEN  rs1 operand
- B  in  XLEN  rs2 operand
- BrOp  in  5  branch operation (encoding below)
- pred_i  in  1  prediction that was made for this instruction at fetch
- NextPCSrc  out  1  1 = take branch/jump target
- flush_o  out  1  redirect fetch, squash younger instructions
- br_cnt_o  out  STAT_W  resolved conditional branches
- mispred_cnt_o  out  STAT_W  mispredicted conditional branches + jumps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- BrOp decode:
  - 00xxx: no branch; NextPCSrc=0.
  - 1xxxx: unconditional jump; NextPCSrc=1.
  - 01xxx: conditional branch, low 3 bits = funct3:
    - 000 BEQ: A==B
    - 001 BNE: A!=B
    - 100 BLT: signed A<B
    - 101 BGE: signed A>=B
    - 110 BLTU: unsigned A<B
    - 111 BGEU: unsigned A>=B
    - 010, 011: NextPCSrc=0, treated as no-branch (no update, no count).
- NextPCSrc: purely combinational, independent of res_valid_i and rst. It matches the single-cycle BU exactly for XLEN=32.
- Index: idx = PC[$clog2(BHT_ENTRIES)+1:2]. The same function is used for lookup and update.
- Lookup: combinational. pred_taken_o = bht[idx(pred_pc_i)][1].
- flush_o (combinational), asserted when res_valid_i and either:
  - a valid conditional branch with NextPCSrc != pred_i, or
  - a jump (jumps are never predicted by fetch).
  - Forced to 0 while rst=1.
- Update, at rising clk when res_valid_i, BrOp is a valid conditional branch, and !rst:
  - taken: counter = min(counter+1, 2'b11)
  - not taken: counter = max(counter-1, 2'b00)
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Read-during-write, same index same cycle: lookup returns the pre-update value. The new value is visible the next cycle.
- Statistics: saturating at all-ones, never wrap.
  - br_cnt_o +1 per valid conditional branch.
  - mispred_cnt_o +1 per cycle with flush_o=1.
- Reset values: all BHT entries=2'b01; br_cnt_o=0; mispred_cnt_o=0. Hence pred_taken_o=0 the cycle after reset.
- Reset mid-operation: rst dominates any simultaneous update or count; no partial update survives.
- Latency: resolve/flush 0 cycles; training effect 1 cycle.

Decomposition:
- Package bu_pkg holds:
  - BrOp constants: BR_NONE prefix 2'b00, BR_COND prefix 2'b01, BR_JUMP MSB, and funct3 codes F3_BEQ..F3_BGEU.
  - typedef bht_ctr_t (2-bit), with constants CTR_SNT/WNT/WT/ST.
- Sub-module bu_cmp (combinational): inputs A, B, BrOp; outputs taken, is_cond, is_jump.
- bu_bht instantiates bu_cmp and holds the BHT array, update logic and statistics.

Test Plan:
1. Reset → pred_taken_o=0 for pred_pc_i=0x00, 0x40, 0xFC; br_cnt_o=0, mispred_cnt_o=0.
2. res_pc_i=0x40, BEQ (01000), A=5, B=5, pred_i=0 → NextPCSrc=1, flush_o=1 same cycle. Next cycle: lookup 0x40 gives pred_taken_o=1 (01→10); br_cnt_o=1, mispred_cnt_o=1.
3. Three more taken BEQ at 0x40 with pred_i=1 → flush_o=0, counter saturates at 11. Then BNE with A=B=5 (not taken) → counter 10, pred_taken_o still 1, flush_o=1.
4. A=0xFFFFFFFB, B=7, one op per cycle:
   - BLT → NextPCSrc=1
   - BGE → 0
   - BLTU → 0
   - BGEU → 1
5. BrOp=11111 and BrOp=10000 with res_valid_i=1 → NextPCSrc=1, flush_o=1, mispred_cnt_o +1, br_cnt_o unchanged, no BHT change. BrOp=01010 → NextPCSrc=0, flush_o=0, nothing updated.
6. Boundary cases:
   - Lookup and update of 0x40 in the same cycle → old value shown; new value next cycle.
   - PC 0x40 and 0x140 alias at 64 entries and share one counter.
   - rst=1 together with a taken BEQ → counter stays 01.
   - STAT_W=4: 20 branches → br_cnt_o=15.
